uc_frame_rx: RTL and testbench
==============================

# uc_frame_rx

Parametrised slow-line command receiver. Its input is a single Manchester-coded serial line from the partner CPLD. It divides the system clock down to a sampling tick, arms on a high preamble, and checks a start chip. It then decodes NBITS Manchester bits with 3-sample majority voting, checks a stop chip and range-checks the result. Valid codes are latched on `cmd_o` for the front-panel/control logic. Malformed frames are reported with an error class, where the previous generation dropped them silently.

## Interface
- `CLK_DIV`, 69444: clk cycles per sampling tick (≥2)
- `OSR`, 8: ticks per Manchester chip (half-bit), ≥4
- `NBITS`, 6: data bits per frame, MSB first
- `PRE_LEN`, 9: consecutive high ticks required to arm
- `HOLDOFF`, 15: ticks ignored after a good frame
- `MAX_CODE`, 24: largest accepted code
- `IDLE_CODE`, 25: `cmd_o` reset value (must fit NBITS)
- `clk`  in  1  system clock, 40 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_i`  in  1  serial line, asynchronous to clk
- `cmd_o`  out  NBITS  last accepted code
- `valid_o`  out  1  one-clk pulse when `cmd_o` updates
- `err_o`  out  1  one-clk pulse on frame error
- `err_code_o`  out  3  error class, held until next error/frame
- `busy_o`  out  1  high in START, DATA, STOP, HOLD
- `tick_o`  out  1  sampling tick, debug

## Operation
- `rx_i` passes through a 2-flop synchroniser to give `rx_s`. The FSM looks at `rx_s` only on tick cycles.
- **IDLE.** `hi_cnt` counts consecutive high ticks, saturating at PRE_LEN. A low tick clears it. When `hi_cnt`==PRE_LEN, go to SYNC.
- **SYNC.** Wait for the first low tick; that tick is k=0 of the start chip, then go to START. Staying high keeps the FSM in SYNC indefinitely.
- **Chip sampling.**
  - Every chip runs k=0..OSR-1 ticks.
  - Samples are taken at k=OSR/2-1, OSR/2 and OSR/2+1; the chip value is the majority of the three.
  - The chip ends at k=OSR-1 and the next chip begins at k=0 on the following tick.
- **START.** The majority must be 0. Otherwise `err_code` = 1 (START) and go to IDLE.
- **DATA.** There are 2·NBITS chips, decoded in pairs:
  - 01 gives bit 0; 10 gives bit 1.
  - 00 or 11 gives `err_code` = 2 (MANCH) and an immediate abort to IDLE once the second chip is decided.
  - Bits shift into a shift register, MSB first.
- **STOP.** One chip whose majority must be 1. Otherwise `err_code` = 3 (STOP) and go to IDLE.
- **Range check.** After a good stop chip:
  - code ≤ MAX_CODE: `cmd_o` ← code, `valid_o` pulses, go to HOLD.
  - otherwise: `err_code` = 4 (RANGE), `cmd_o` is unchanged, go to IDLE.
- **HOLD.** Ignore the line for HOLDOFF ticks, then go to IDLE with `hi_cnt`=0.
- Every error path clears `hi_cnt`, so re-arming always needs a fresh PRE_LEN preamble.
- **Reset values:** `cmd_o`=IDLE_CODE, `valid_o`=`err_o`=`busy_o`=`tick_o`=0, `err_code_o`=0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts with no error pulse.

## Timing
- The prescaler runs 0..CLK_DIV-1. `tick_o` is high for one clk when the count is CLK_DIV-1.
- Line-to-decision latency is 2 clk (synchroniser) plus tick quantisation.
- `valid_o` and `err_o` are registered. Each is high for the single clk after the tick on which the deciding sample (k=OSR/2+1) is taken, and they are never both high.
- `cmd_o` changes in the same clk that `valid_o` is high.
- `err_code_o` updates together with `err_o`, and is cleared to 0 together with a `valid_o` pulse.
- A frame lasts (2·NBITS+2)·OSR ticks after the preamble. With defaults that is 112 ticks, about 194 ms.
- Line activity during HOLD or between sample points has no effect.

## Structure
- Package `uc_rx_pkg` contains:
  - state enum {IDLE, SYNC, START, DATA, STOP, HOLD};
  - error constants ERR_NONE=0, ERR_START=1, ERR_MANCH=2, ERR_STOP=3, ERR_RANGE=4.
- Sub-module `uc_tick_gen` is the parametrised prescaler (`clk`, `rst_n` → `tick`) and is reused by the TX side.
- Counter widths use $clog2 of CLK_DIV, OSR, 2·NBITS and max(PRE_LEN, HOLDOFF), each plus 1.

## Test plan
Bench parameters: CLK_DIV=4, other parameters at default. The frame shape is a 9-tick-high preamble, a start chip of 0, the data chips, then a stop chip of 1.

- Frame with code 5 (chips 01 01 01 10 01 10) → one `valid_o` pulse, `cmd_o`=5, `err_o` never high.
- Frame with code 30 → `err_o` pulse with `err_code_o`=4; `cmd_o` keeps its prior value.
- Frame whose third bit is chips 11 → `err_o` with code 2 at the end of chip 6. A following good frame with code 7 then gives `cmd_o`=7.
- Frame with code 12 plus a 1-tick inverted glitch at k=OSR/2 of every chip → still `cmd_o`=12, no error.
- Preamble only 8 ticks high then low → no output at all; `busy_o` stays 0.
- Stop chip forced low → `err_code_o`=3. Separately, `rst_n` pulsed during DATA → `cmd_o`=25, all pulses 0, and the next frame decodes normally.

Source files
------------

// File: rtl/uc_rx_pkg.sv
// uc_rx_pkg: shared states, error classes and helpers for the Manchester command receiver
package uc_rx_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP, HOLD} state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_START = 3'd1;
    localparam logic [2:0] ERR_MANCH = 3'd2;
    localparam logic [2:0] ERR_STOP  = 3'd3;
    localparam logic [2:0] ERR_RANGE = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uc_tick_gen.sv
// uc_tick_gen: free-running prescaler giving a one-clk tick every CLK_DIV clocks
module uc_tick_gen #(
    parameter int CLK_DIV = 69444
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // tick on the last count, then wrap to zero
    always_comb begin
        tick  = cnt_q == CW'(CLK_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // prescaler counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uc_frame_rx.sv
// uc_frame_rx: Manchester command receiver with preamble arming, majority voting and error reporting
module uc_frame_rx
    import uc_rx_pkg::*;
#(
    parameter int CLK_DIV   = 69444,
    parameter int OSR       = 8,
    parameter int NBITS     = 6,
    parameter int PRE_LEN   = 9,
    parameter int HOLDOFF   = 15,
    parameter int MAX_CODE  = 24,
    parameter int IDLE_CODE = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_i,
    output logic [NBITS-1:0] cmd_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [2:0]       err_code_o,
    output logic             busy_o,
    output logic             tick_o
);

    localparam int OW = $clog2(OSR) + 1;
    localparam int BW = $clog2(2 * NBITS) + 1;
    localparam int HW = $clog2((PRE_LEN > HOLDOFF) ? PRE_LEN : HOLDOFF) + 1;

    logic             tick;
    state_t           state_q, state_d;
    logic             rx_m_q, rx_m_d, rx_s_q, rx_s_d;
    logic [HW-1:0]    hi_q, hi_d, hold_q, hold_d;
    logic [OW-1:0]    k_q, k_d;
    logic [BW-1:0]    chip_q, chip_d;
    logic             s1_q, s1_d, s2_q, s2_d, first_q, first_d;
    logic [NBITS-1:0] sh_q, sh_d, cmd_q, cmd_d;
    logic             valid_q, valid_d, err_q, err_d;
    logic [2:0]       ecode_q, ecode_d;
    logic             maj, in_chip, dec, chip_end, bad, in_range;

    uc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // the third sample arrives live on the deciding tick; the first two were stored
    assign maj      = maj3(s1_q, s2_q, rx_s_q);
    assign in_chip  = state_q inside {START, DATA, STOP};
    assign dec      = tick && in_chip && k_q == OW'(OSR / 2 + 1);
    assign chip_end = tick && k_q == OW'(OSR - 1);
    assign bad      = dec && state_q == DATA && chip_q[0] && first_q == maj;
    assign in_range = int'(sh_q) <= MAX_CODE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state: errors abort at the decision tick, good chips run to their last tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hi_q == HW'(PRE_LEN)) state_d = SYNC;
            SYNC:    if (tick && !rx_s_q) state_d = START;
            START:   if (dec && maj) state_d = IDLE;
                     else if (chip_end) state_d = DATA;
            DATA:    if (bad) state_d = IDLE;
                     else if (chip_end && chip_q == BW'(2 * NBITS - 1)) state_d = STOP;
            STOP:    if (dec) state_d = (maj && in_range) ? HOLD : IDLE;
            HOLD:    if (tick && hold_q == HW'(HOLDOFF - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath and registered pulse outputs
    always_comb begin
        rx_m_d  = rx_i;
        rx_s_d  = rx_m_q;
        hi_d    = (state_q != IDLE) ? '0 : !tick ? hi_q : !rx_s_q ? '0 :
                  (hi_q == HW'(PRE_LEN)) ? hi_q : hi_q + HW'(1);
        k_d     = (state_q == SYNC) ? ((tick && !rx_s_q) ? OW'(1) : '0) :
                  !in_chip ? '0 : !tick ? k_q : chip_end ? '0 : k_q + OW'(1);
        s1_d    = (tick && in_chip && k_q == OW'(OSR / 2 - 1)) ? rx_s_q : s1_q;
        s2_d    = (tick && in_chip && k_q == OW'(OSR / 2)) ? rx_s_q : s2_q;
        chip_d  = (state_q != DATA) ? '0 : chip_end ? chip_q + BW'(1) : chip_q;
        first_d = (dec && state_q == DATA && !chip_q[0]) ? maj : first_q;
        sh_d    = (dec && state_q == DATA && chip_q[0] && !bad) ? NBITS'({sh_q, first_q}) : sh_q;
        hold_d  = (state_q != HOLD) ? '0 : tick ? hold_q + HW'(1) : hold_q;
        valid_d = dec && state_q == STOP && maj && in_range;
        err_d   = bad || (dec && state_q == START && maj) ||
                  (dec && state_q == STOP && !(maj && in_range));
        ecode_d = err_d ? ((state_q == START) ? ERR_START : (state_q == DATA) ? ERR_MANCH :
                           !maj ? ERR_STOP : ERR_RANGE) :
                  valid_d ? ERR_NONE : ecode_q;
        cmd_d   = valid_d ? sh_q : cmd_q;
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q  <= 1'b0;
            rx_s_q  <= 1'b0;
            hi_q    <= '0;
            k_q     <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            chip_q  <= '0;
            first_q <= 1'b0;
            sh_q    <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= ERR_NONE;
            cmd_q   <= NBITS'(IDLE_CODE);
        end else begin
            rx_m_q  <= rx_m_d;
            rx_s_q  <= rx_s_d;
            hi_q    <= hi_d;
            k_q     <= k_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            chip_q  <= chip_d;
            first_q <= first_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
            cmd_q   <= cmd_d;
        end
    end

    assign cmd_o      = cmd_q;
    assign valid_o    = valid_q;
    assign err_o      = err_q;
    assign err_code_o = ecode_q;
    assign busy_o     = state_q inside {START, DATA, STOP, HOLD};
    assign tick_o     = tick;

endmodule

// File: tb/tb_uc_frame_rx.sv
// tb_uc_frame_rx: directed frames with a scoreboard checked by an independent output monitor
module tb_uc_frame_rx;
    import uc_rx_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int OSR     = 8;
    localparam int GAP     = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic [5:0] cmd_o;
    logic       valid_o, err_o, busy_o, tick_o;
    logic [2:0] err_code_o;

    typedef struct {
        bit         is_err;
        logic [5:0] cmd;
        logic [2:0] code;
        int         at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_n = 0;

    uc_frame_rx #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .cmd_o      (cmd_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .busy_o     (busy_o),
        .tick_o     (tick_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick_n);
        end
    endtask

    // chip vector: bit 13 is the start chip, bit 0 the stop chip
    function automatic logic [13:0] mk(input logic [5:0] code);
        logic [13:0] f;
        f[13] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            f[12 - 2 * i] = code[5 - i];
            f[11 - 2 * i] = ~code[5 - i];
        end
        f[0] = 1'b1;
        return f;
    endfunction

    task automatic tk(input logic v);
        rx_i = v;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        tick_n++;
    endtask

    task automatic align();
        int n = 0;
        @(negedge clk);
        while (!tick_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tick_o) begin
            $display("FAIL align: no tick_o within 20 clocks");
            $fatal(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] f, input bit glitch, input int gap);
        repeat (gap) tk(1'b1);
        for (int c = 0; c < 14; c++)
            for (int k = 0; k < OSR; k++)
                tk((glitch && k == OSR / 2) ? ~f[13 - c] : f[13 - c]);
    endtask

    // the deciding sample of chip c is tick f0+8c+5; the pulse is seen after it completes
    task automatic expect_ev(input bit is_err, input logic [5:0] cmd, input logic [2:0] code,
                             input int chip_idx);
        q.push_back('{is_err, cmd, code, tick_n + GAP + OSR * chip_idx + OSR / 2 + 2});
    endtask

    always @(negedge clk) begin
        if (rst_n && (valid_o || err_o)) begin
            exp_t e;
            chk("pulse_exclusive", 32'(valid_o && err_o), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0d err=%0d code=%0d cmd=%0d, expected no pulse",
                         valid_o, err_o, err_code_o, cmd_o);
            end else begin
                e = q.pop_front();
                chk("pulse_kind_err", 32'(err_o), 32'(e.is_err));
                chk("cmd_o", 32'(cmd_o), 32'(e.cmd));
                chk("err_code_o", 32'(err_code_o), 32'(e.code));
                chk("pulse_tick", tick_n, e.at);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [13:0] f;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", 32'(cmd_o), 25);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_err_code", 32'(err_code_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_tick", 32'(tick_o), 0);
        rst_n = 1'b1;
        align();

        expect_ev(0, 6'd5, ERR_NONE, 13);
        send(mk(6'd5), 0, GAP);

        expect_ev(1, 6'd5, ERR_RANGE, 13);
        send(mk(6'd30), 0, GAP);

        f = 14'b0_0101_11_010101_1;
        expect_ev(1, 6'd5, ERR_MANCH, 6);
        send(f, 0, GAP);

        expect_ev(0, 6'd7, ERR_NONE, 13);
        send(mk(6'd7), 0, GAP);

        expect_ev(0, 6'd12, ERR_NONE, 13);
        send(mk(6'd12), 1, GAP);

        repeat (25) tk(1'b0);
        repeat (8) begin
            tk(1'b1);
            chk("short_pre_busy", 32'(busy_o), 0);
        end
        repeat (20) begin
            tk(1'b0);
            chk("short_pre_busy", 32'(busy_o), 0);
        end

        f = mk(6'd3);
        f[0] = 1'b0;
        expect_ev(1, 6'd12, ERR_STOP, 13);
        send(f, 0, GAP);

        f = mk(6'd9);
        repeat (GAP) tk(1'b1);
        for (int c = 0; c < 5; c++)
            for (int k = 0; k < OSR; k++)
                tk(f[13 - c]);
        chk("busy_in_data", 32'(busy_o), 1);
        rst_n = 1'b0;
        #2;
        chk("midrst_cmd", 32'(cmd_o), 25);
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_err", 32'(err_o), 0);
        chk("midrst_err_code", 32'(err_code_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rx_i = 1'b1;
        rst_n = 1'b1;
        align();

        expect_ev(0, 6'd17, ERR_NONE, 13);
        send(mk(6'd17), 0, GAP);

        repeat (30) tk(1'b1);
        chk("queue_empty", q.size(), 0);
        chk("final_cmd", 32'(cmd_o), 17);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
